piped_mac_multilane: RTL

//  Parametrised successor to the single-lane pipelined MAC.

---
 rtl/piped_mac_multilane.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/piped_mac_multilane.sv
// piped_mac_multilane
//   Multi-lane pipelined multiply-accumulate engine. Each accepted AXI-Stream
//   beat carries LANES signed activation/weight pairs. The products are summed
//   by a balanced adder tree and accumulated across the beats of a packet. One
//   ACC_WIDTH result leaves per packet, three cycles after its TLAST beat is
//   accepted.
//
//   Pipeline: S1 lane products -> S2 adder tree -> S3 accumulate / result.
//   Every stage freezes while a result is waiting for MO_AXIS_TREADY.
//
//   Build option: define PIPED_MAC_SAT_EN to clamp every accumulate step to
//   the signed ACC_WIDTH range. When it is undefined, the accumulator wraps
//   modulo 2^ACC_WIDTH.
//
// Ports
//   ACLK, ARESET     clock; synchronous active-high reset
//   SD_AXIS_*        input beats: TDATA lane i act=[2iW+:W], wgt=[(2i+1)W+:W],
//                    TUSER = clear before add, TLAST = end of dot product,
//                    TID sampled on the TLAST beat
//   MO_AXIS_*        one-beat result packets (TLAST mirrors TVALID)
module piped_mac_multilane #(
  parameter int C_DATA_WIDTH = 8,
  parameter int LANES        = 4,
  parameter int ACC_WIDTH    = 32,
  parameter int TID_WIDTH    = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  output logic                            SD_AXIS_TREADY,
  input  logic [2*C_DATA_WIDTH*LANES-1:0] SD_AXIS_TDATA,
  input  logic                            SD_AXIS_TLAST,
  input  logic                            SD_AXIS_TUSER,
  input  logic                            SD_AXIS_TVALID,
  input  logic [TID_WIDTH-1:0]            SD_AXIS_TID,
  output logic                            MO_AXIS_TVALID,
  output logic [ACC_WIDTH-1:0]            MO_AXIS_TDATA,
  output logic                            MO_AXIS_TLAST,
  input  logic                            MO_AXIS_TREADY,
  output logic [TID_WIDTH-1:0]            MO_AXIS_TID
);

  localparam int W      = C_DATA_WIDTH;
  localparam int PROD_W = 2 * W;
  localparam int SUM_W  = PROD_W + $clog2(LANES);
  // One guard bit above the wider of accumulator and tree sum, so that a single
  // add can never overflow before it is clamped or wrapped.
  localparam int EXT_W  = ((ACC_WIDTH > SUM_W) ? ACC_WIDTH : SUM_W) + 1;

  localparam logic signed [EXT_W-1:0] ACC_MAX =
    $signed({{(EXT_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}});
  localparam logic signed [EXT_W-1:0] ACC_MIN =
    $signed({{(EXT_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}});

  // Reduce an extended accumulate result to ACC_WIDTH (clamp or wrap).
  function automatic logic signed [ACC_WIDTH-1:0] fit_acc(input logic signed [EXT_W-1:0] v);
`ifdef PIPED_MAC_SAT_EN
    if (v > ACC_MAX) begin
      fit_acc = ACC_MAX[ACC_WIDTH-1:0];
    end else if (v < ACC_MIN) begin
      fit_acc = ACC_MIN[ACC_WIDTH-1:0];
    end else begin
      fit_acc = v[ACC_WIDTH-1:0];
    end
`else
    fit_acc = v[ACC_WIDTH-1:0];
`endif
  endfunction

  logic advance_s;
  logic beat_in_s;

  logic signed [PROD_W-1:0] prod_s [LANES];
  logic signed [PROD_W-1:0] prod_r [LANES];
  logic                     s1_valid_r, s1_last_r, s1_user_r;
  logic [TID_WIDTH-1:0]     s1_tid_r;

  logic signed [SUM_W-1:0]  tree_sum_s;
  logic signed [SUM_W-1:0]  s2_sum_r;
  logic                     s2_valid_r, s2_last_r, s2_user_r;
  logic [TID_WIDTH-1:0]     s2_tid_r;

  logic signed [EXT_W-1:0]     acc_base_s;
  logic signed [ACC_WIDTH-1:0] acc_next_s;
  logic signed [ACC_WIDTH-1:0] acc_r;
  logic                        first_r;   // next beat starts a fresh sum
  logic                        mo_tvalid_r;
  logic [ACC_WIDTH-1:0]        mo_tdata_r;
  logic [TID_WIDTH-1:0]        mo_tid_r;

  // The whole pipeline moves unless a result is stuck at the output.
  assign advance_s      = ~(mo_tvalid_r & ~MO_AXIS_TREADY);
  assign SD_AXIS_TREADY = advance_s & ~ARESET;
  assign beat_in_s      = SD_AXIS_TVALID & SD_AXIS_TREADY;

  // Per-lane signed products of the incoming beat.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_s[i] = PROD_W'($signed(SD_AXIS_TDATA[2*i*W +: W])) *
                  PROD_W'($signed(SD_AXIS_TDATA[(2*i+1)*W +: W]));
    end
  end

  // S1: register products and beat tags.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_user_r  <= 1'b0;
      s1_tid_r   <= '0;
      for (int i = 0; i < LANES; i++) prod_r[i] <= '0;
    end else if (advance_s) begin
      s1_valid_r <= beat_in_s;
      s1_last_r  <= SD_AXIS_TLAST;
      s1_user_r  <= SD_AXIS_TUSER;
      s1_tid_r   <= SD_AXIS_TID;
      for (int i = 0; i < LANES; i++) prod_r[i] <= prod_s[i];
    end
  end

  // Balanced adder tree in heap layout: leaves at LANES-1.., node i sums its
  // children 2i+1 and 2i+2, root at index 0. Built bottom-up.
  always_comb begin
    logic signed [SUM_W-1:0] node [2*LANES-1];
    for (int i = 0; i < 2*LANES-1; i++) node[i] = '0;
    for (int i = 0; i < LANES; i++) node[LANES-1+i] = SUM_W'(prod_r[i]);
    for (int i = LANES-2; i >= 0; i--) node[i] = node[2*i+1] + node[2*i+2];
    tree_sum_s = node[0];
  end

  // S2: register the tree sum and tags.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s2_valid_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_user_r  <= 1'b0;
      s2_tid_r   <= '0;
      s2_sum_r   <= '0;
    end else if (advance_s) begin
      s2_valid_r <= s1_valid_r;
      s2_last_r  <= s1_last_r;
      s2_user_r  <= s1_user_r;
      s2_tid_r   <= s1_tid_r;
      s2_sum_r   <= tree_sum_s;
    end
  end

  // Next accumulator value: restart on TUSER or on the first beat after TLAST.
  always_comb begin
    acc_base_s = '0;
    if (s2_user_r | first_r) begin
      acc_base_s = '0;
    end else begin
      acc_base_s = EXT_W'(acc_r);
    end
    acc_next_s = fit_acc(acc_base_s + EXT_W'(s2_sum_r));
  end

  // S3: accumulate; on TLAST publish the result and arm an implicit clear.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      acc_r       <= '0;
      first_r     <= 1'b1;
      mo_tvalid_r <= 1'b0;
      mo_tdata_r  <= '0;
      mo_tid_r    <= '0;
    end else if (advance_s) begin
      if (s2_valid_r) begin
        if (s2_last_r) begin
          acc_r       <= '0;
          first_r     <= 1'b1;
          mo_tvalid_r <= 1'b1;
          mo_tdata_r  <= acc_next_s;
          mo_tid_r    <= s2_tid_r;
        end else begin
          acc_r       <= acc_next_s;
          first_r     <= 1'b0;
          mo_tvalid_r <= 1'b0;
        end
      end else begin
        mo_tvalid_r <= 1'b0;
      end
    end
  end

  assign MO_AXIS_TVALID = mo_tvalid_r;
  assign MO_AXIS_TLAST  = mo_tvalid_r;
  assign MO_AXIS_TDATA  = mo_tdata_r;
  assign MO_AXIS_TID    = mo_tid_r;

endmodule
